// File: rtl/regfile_sb.sv
// regfile_sb: register file with per-register scoreboard, bypassed read ports and flat debug bus
module regfile_sb #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 8,
    parameter int AW      = $clog2(DEPTH),
    parameter int ZERO_R0 = 0,
    parameter int BYPASS  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we,
    input  logic [AW-1:0]          waddr,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   rsv,
    input  logic [AW-1:0]          rsv_addr,
    input  logic [AW-1:0]          sa,
    input  logic [AW-1:0]          sb,
    output logic [WIDTH-1:0]       opa,
    output logic [WIDTH-1:0]       opb,
    output logic                   rdy_a,
    output logic                   rdy_b,
    output logic [DEPTH-1:0]       busy,
    output logic [WIDTH*DEPTH-1:0] dbg_regs
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic wok, byp_a, byp_b, za, zb;

    // a write to r0 is discarded when r0 is hardwired to zero
    assign wok   = we && !(ZERO_R0 != 0 && waddr == '0);
    assign byp_a = BYPASS != 0 && wok && waddr == sa;
    assign byp_b = BYPASS != 0 && wok && waddr == sb;
    assign za    = ZERO_R0 != 0 && sa == '0;
    assign zb    = ZERO_R0 != 0 && sb == '0;

    // storage and scoreboard; a reserve wins over a same-cycle write to the same register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            busy <= '0;
        end else begin
            if (wok) mem[waddr] <= wdata;
            for (int i = 0; i < DEPTH; i++)
                busy[i] <= (rsv && rsv_addr == AW'(i) && !(ZERO_R0 != 0 && i == 0)) ? 1'b1 :
                           (we && waddr == AW'(i)) ? 1'b0 : busy[i];
        end
    end

    // combinational read ports with optional forwarding of the in-flight write
    always_comb begin
        opa   = byp_a ? wdata : za ? '0 : mem[sa];
        opb   = byp_b ? wdata : zb ? '0 : mem[sb];
        rdy_a = byp_a || za || !busy[sa];
        rdy_b = byp_b || zb || !busy[sb];
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_dbg
        assign dbg_regs[g*WIDTH +: WIDTH] = mem[g];
    end
endmodule
